if_id_fifo: RTL and testbench

Parametrised, elastic successor to the single-entry IF→ID pipeline register. It sits between instruction fetch and decode. It buffers up to DEPTH {pc, instruction} pairs behind a valid/ready handshake on both sides, so fetch can run ahead of a stalled decode without dropping or duplicating instructions. When the block is empty it presents a NOP bubble downstream. It supports a synchronous stage flush (branch/jump redirect) and a global chip-ready hold.

---
 rtl/if_id_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_if_id_fifo.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// -----------------------------------------------------------------------------
// if_id_fifo
//
// Elastic IF->ID pipeline buffer. Holds up to DEPTH {pc, instruction} pairs
// between instruction fetch and decode behind a valid/ready handshake on both
// sides, so fetch can run ahead of a stalled decode without dropping or
// duplicating instructions. While empty, the downstream side presents a NOP
// bubble (NOP_PC / NOP_INS) with dn_valid low.
//
// Parameters
//   PC_W     PC width
//   INS_W    instruction width
//   DEPTH    number of entries (power of two, >= 2)
//   NOP_PC   PC presented while empty
//   NOP_INS  instruction presented while empty (addi x0,x0,0)
//
// Ports
//   clk_in      single clock, all state updates on the rising edge
//   rst_in      asynchronous active-low reset
//   rdy_in      chip ready; low freezes every register (clear still wins)
//   clear       synchronous flush (branch/jump redirect), active-high
//   up_valid    fetch offers {up_pc, up_ins}
//   up_ready    buffer can accept an entry this cycle
//   up_pc       fetched PC
//   up_ins      fetched instruction
//   dn_valid    head entry is valid for decode
//   dn_ready    decode consumes the head entry
//   dn_pc       head PC, or NOP_PC while empty
//   dn_ins      head instruction, or NOP_INS while empty
//   count       number of occupied entries, 0..DEPTH
//
// Optional build macro
//   IF_ID_PERF_EN  adds saturating 32-bit performance counters:
//     stall_cnt   cycles with rdy_in & up_valid & !up_ready
//     bubble_cnt  cycles with rdy_in & dn_ready & !dn_valid
//   Both reset to 0 and ignore clear. Without the macro the ports and the
//   counters do not exist and everything else behaves identically.
// -----------------------------------------------------------------------------
module if_id_fifo #(
    parameter int               PC_W    = 32,
    parameter int               INS_W   = 32,
    parameter int               DEPTH   = 2,
    parameter logic [PC_W-1:0]  NOP_PC  = '0,
    parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h0000_0013)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear,

    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [PC_W-1:0]            up_pc,
    input  logic [INS_W-1:0]           up_ins,

    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [PC_W-1:0]            dn_pc,
    output logic [INS_W-1:0]           dn_ins,

    output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt
`endif
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } entry_t;

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    entry_t           mem [DEPTH];
    entry_t           head;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A full buffer refuses a new entry even when decode drains the head in
    // the same cycle, so up_ready never depends on dn_ready. rst_in is folded
    // in so fetch sees the block as not ready for the whole reset window.
    assign up_ready = rst_in & rdy_in & ~full;
    assign dn_valid = rdy_in & ~empty;

    // clear discards whatever transfer was offered in the flush cycle.
    assign push = up_valid & up_ready & ~clear;
    assign pop  = dn_valid & dn_ready & ~clear;

    // -------------------------------------------------------------------------
    // Downstream data: a mux of registers only, so there is never a
    // combinational path from up_* to dn_*. A freshly pushed entry shows up
    // one cycle after the edge that accepted it.
    // -------------------------------------------------------------------------
    assign head   = mem[rd_ptr];
    assign dn_pc  = empty ? NOP_PC  : head.pc;
    assign dn_ins = empty ? NOP_INS : head.ins;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;

        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural
            // overflow of a PTR_W-bit add.
            if (push) begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    // NOTE: the entry array is deliberately not reset. Its contents are only
    // visible through dn_* while count != 0, and count is reset, so a reset
    // here would only cost area and routing.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{pc: up_pc, ins: up_ins};
        end
    end

`ifdef IF_ID_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: saturating, cleared only by reset.
    // -------------------------------------------------------------------------
    logic stall_ev;
    logic bubble_ev;

    assign stall_ev  = rdy_in & up_valid & ~up_ready;
    assign bubble_ev = rdy_in & dn_ready & ~dn_valid;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (bubble_ev && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// -----------------------------------------------------------------------------
// tb_if_id_fifo
//
// Self-checking bench for if_id_fifo (DEPTH = 2). A queue-based reference
// model tracks the buffered {pc, ins} pairs; expected outputs come from the
// queue contents and the current control inputs. Inputs change one time unit
// after the rising edge and outputs are sampled a further time unit later.
// The performance-counter scenario is compiled only with IF_ID_PERF_EN.
// -----------------------------------------------------------------------------
module tb_if_id_fifo;

    localparam int          PC_W    = 32;
    localparam int          INS_W   = 32;
    localparam int          DEPTH   = 2;
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;
    localparam int          VW      = 2 + CW + PC_W + INS_W;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic             clear;
    logic             up_valid;
    logic             up_ready;
    logic [PC_W-1:0]  up_pc;
    logic [INS_W-1:0] up_ins;
    logic             dn_valid;
    logic             dn_ready;
    logic [PC_W-1:0]  dn_pc;
    logic [INS_W-1:0] dn_ins;
    logic [CW-1:0]    count;
`ifdef IF_ID_PERF_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;
`endif

    if_id_fifo #(
        .PC_W    (PC_W),
        .INS_W   (INS_W),
        .DEPTH   (DEPTH),
        .NOP_PC  (NOP_PC),
        .NOP_INS (NOP_INS)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_pc    (up_pc),
        .up_ins   (up_ins),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_pc    (dn_pc),
        .dn_ins   (dn_ins),
        .count    (count)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [PC_W+INS_W-1:0] mq[$];
    longint                m_stall  = 0;
    longint                m_bubble = 0;

    function automatic logic exp_up_ready();
        return rst_in && rdy_in && (mq.size() < DEPTH);
    endfunction

    function automatic logic exp_dn_valid();
        return rdy_in && (mq.size() != 0);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
        pc  = NOP_PC;
        ins = NOP_INS;
        if (mq.size() != 0) begin
            pc  = mq[0][PC_W+INS_W-1:INS_W];
            ins = mq[0][INS_W-1:0];
        end
        return {exp_dn_valid(), exp_up_ready(), CW'(mq.size()), pc, ins};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {dn_valid, up_ready, count, dn_pc, dn_ins};
    endfunction

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick();
        logic ur, dv, psh, pp;
        ur  = exp_up_ready();
        dv  = exp_dn_valid();
        psh = up_valid && ur && !clear;
        pp  = dv && dn_ready && !clear;
        @(posedge clk_in);
        if (rst_in) begin
            if (rdy_in && up_valid && !ur && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (rdy_in && dn_ready && !dv && m_bubble < 64'hFFFF_FFFF) m_bubble++;
            if (clear) begin
                mq.delete();
            end else begin
                if (pp) void'(mq.pop_front());
                if (psh) mq.push_back({up_pc, up_ins});
            end
        end
        #1;
    endtask

    task automatic set_in(input logic uv, input logic [31:0] pc, input logic [31:0] ins,
                          input logic dr, input logic rdy, input logic clr);
        up_valid = uv;
        up_pc    = pc;
        up_ins   = ins;
        dn_ready = dr;
        rdy_in   = rdy;
        clear    = clr;
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_in = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (up_ready !== 1'b0) $display("FAIL reset_up_ready_in_reset: got %b want 0", up_ready);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL reset_outputs_in_reset: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        tick();
        tick();
        #3 rst_in = 1'b1;
        #1;
        n_checks++;
        if (dn_valid !== 1'b0) $display("FAIL reset_dn_valid: got %b want 0", dn_valid);
        else n_pass++;
        n_checks++;
        if (dn_pc !== 32'h0) $display("FAIL reset_dn_pc: got %h want 0", dn_pc);
        else n_pass++;
        n_checks++;
        if (dn_ins !== 32'h0000_0013) $display("FAIL reset_dn_ins: got %h want 00000013", dn_ins);
        else n_pass++;
        n_checks++;
        if (count !== '0) $display("FAIL reset_count: got %0d want 0", count);
        else n_pass++;
        n_checks++;
        if (up_ready !== 1'b1) $display("FAIL reset_up_ready: got %b want 1", up_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_fill_drain();
        set_in(1'b1, 32'h100, 32'hAA, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h104, 32'hBB, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dn_pc !== 32'h100 || dn_valid !== 1'b1) $display("FAIL fill_latency: got pc %h v %b want 100 1", dn_pc, dn_valid);
        else n_pass++;
        tick();
        // Full and decode ready: the offered entry must not be taken this cycle.
        set_in(1'b1, 32'h108, 32'hCC, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (count !== CW'(2) || up_ready !== 1'b0) $display("FAIL fill_full: got count %0d rdy %b want 2 0", count, up_ready);
        else n_pass++;
        n_checks++;
        if (dn_pc !== 32'h100 || dn_ins !== 32'hAA) $display("FAIL drain_first: got %h/%h want 100/aa", dn_pc, dn_ins);
        else n_pass++;
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dn_pc !== 32'h104 || dn_ins !== 32'hBB || count !== CW'(1)) $display("FAIL drain_second: got %h/%h count %0d want 104/bb 1", dn_pc, dn_ins, count);
        else n_pass++;
        tick();
        n_checks++;
        if (count !== '0 || dn_valid !== 1'b0) $display("FAIL drain_empty: got count %0d v %b want 0 0", count, dn_valid);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL drain_model: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k <= 16; k++) begin
            set_in(k < 16, 32'(k * 4), $urandom, 1'b1, 1'b1, 1'b0);
            if (k >= 1) begin
                n_checks++;
                if (dn_valid !== 1'b1 || dn_pc !== 32'((k - 1) * 4) || count !== CW'(1))
                    $display("FAIL b2b_step%0d: got v %b pc %h count %0d want 1 %h 1", k, dn_valid, dn_pc, count, (k - 1) * 4);
                else n_pass++;
            end
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL b2b_model%0d: got %h want %h", k, obs_vec(), exp_vec());
            else n_pass++;
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (count !== '0) $display("FAIL b2b_end_count: got %0d want 0", count);
        else n_pass++;
    endtask

    task automatic test_clear();
        // Full buffer, push and pop offered together with clear.
        set_in(1'b1, 32'h200, 32'h11, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h204, 32'h22, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h208, 32'h33, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (count !== '0 || dn_valid !== 1'b0 || dn_ins !== 32'h13 || up_ready !== 1'b1)
            $display("FAIL clear_full: got count %0d v %b ins %h rdy %b want 0 0 13 1", count, dn_valid, dn_ins, up_ready);
        else n_pass++;
        // One entry, accepted-looking push during clear must vanish.
        set_in(1'b1, 32'h300, 32'h44, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h304, 32'h55, 1'b1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (dn_valid !== 1'b0 || dn_pc !== 32'h0 || count !== '0)
                $display("FAIL clear_discard%0d: got v %b pc %h count %0d want 0 0 0", i, dn_valid, dn_pc, count);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_rdy_hold();
        set_in(1'b1, 32'h400, 32'h66, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h404, 32'h77, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (count !== CW'(1) || dn_pc !== 32'h400 || dn_valid !== 1'b0 || up_ready !== 1'b0)
                $display("FAIL hold%0d: got count %0d pc %h v %b rdy %b want 1 400 0 0", i, count, dn_pc, dn_valid, up_ready);
            else n_pass++;
            tick();
        end
        set_in(1'b1, 32'h404, 32'h77, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dn_valid !== 1'b1 || dn_pc !== 32'h400) $display("FAIL hold_resume: got v %b pc %h want 1 400", dn_valid, dn_pc);
        else n_pass++;
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (count !== CW'(1) || dn_pc !== 32'h404 || dn_ins !== 32'h77)
            $display("FAIL hold_transfer: got count %0d %h/%h want 1 404/77", count, dn_pc, dn_ins);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom % 10) < 7, $urandom, $urandom, ($urandom % 10) < 6,
                   ($urandom % 8) != 0, ($urandom % 20) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 32'h500, 32'h88, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 32'h504, 32'h99, 1'b1, 1'b1, 1'b0);
        #2 rst_in = 1'b0;
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        #1;
        n_checks++;
        if (count !== '0 || dn_valid !== 1'b0 || up_ready !== 1'b0 || dn_pc !== 32'h0 || dn_ins !== 32'h13)
            $display("FAIL async_reset: got count %0d v %b rdy %b %h/%h want 0 0 0 0/13", count, dn_valid, up_ready, dn_pc, dn_ins);
        else n_pass++;
`ifdef IF_ID_PERF_EN
        n_checks++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0)
            $display("FAIL async_reset_perf: got %0d/%0d want 0/0", stall_cnt, bubble_cnt);
        else n_pass++;
`endif
        tick();
        #3 rst_in = 1'b1;
        #1;
        // First push is accepted in the first ready cycle after release.
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL async_release: got %h want %h", obs_vec(), exp_vec());
        else n_pass++;
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dn_pc !== 32'h504 || count !== CW'(1)) $display("FAIL async_first_push: got pc %h count %0d want 504 1", dn_pc, count);
        else n_pass++;
        tick();
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_perf();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rst_in = 1'b0;
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
        tick();
        #3 rst_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            set_in(1'b1, 32'(32'h600 + 4 * i), $urandom, 1'b0, 1'b1, 1'b0);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 32'h700, 32'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (stall_cnt !== 32'd5 || stall_cnt !== 32'(m_stall)) $display("FAIL perf_stall: got %0d want 5", stall_cnt);
        else n_pass++;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bubble_cnt !== 32'd4 || bubble_cnt !== 32'(m_bubble)) $display("FAIL perf_bubble: got %0d want 4", bubble_cnt);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b0;
        clear    = 1'b0;
        up_valid = 1'b0;
        up_pc    = '0;
        up_ins   = '0;
        dn_ready = 1'b0;
        #12;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_clear();
        test_rdy_hold();
        test_random();
        test_async_reset();
`ifdef IF_ID_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
